// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
//
// Sequencer for the board LED bank. A host issues mode commands over a
// valid/ready handshake. A prescaler turns clk into base ticks, and a rate
// counter turns those ticks into pattern steps. On each step the current
// pattern advances. The supported patterns are off, binary count, rotating
// chase and blink.
//
// Optional feature (compile-time macro LED_PWM_DIM_EN):
//   Adds a 4-bit cmd_duty input that is latched on accept. A free-running
//   4-bit PWM counter then gates every lit LED, so each lit LED is on only
//   while pwm_cnt < duty_reg. Step timing does not change.
//
// Parameters:
//   CLK_DIV    clk cycles per base tick (must be >= 2)
//   N_LED      number of LEDs driven
//   ACTIVE_LOW 1 = pin low lights the LED, 0 = pin high lights the LED
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   cmd_valid    command present
//   cmd_ready    block can accept a command (low for one cycle after accept)
//   cmd_mode     0=OFF, 1=COUNT, 2=CHASE, 3=BLINK
//   cmd_rate     base ticks per step minus one
//   cmd_pattern  COUNT start value / CHASE seed / BLINK mask
//   cmd_duty     PWM duty 0..15 (only when LED_PWM_DIM_EN is defined)
//   step_pulse   one-cycle strobe on each pattern step
//   led          registered LED drive
// -----------------------------------------------------------------------------
module led_pattern_ctrl #(
  parameter int CLK_DIV    = 2500000,
  parameter int N_LED      = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [3:0]       cmd_rate,
  input  logic [N_LED-1:0] cmd_pattern,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]       cmd_duty,
`endif
  output logic             step_pulse,
  output logic [N_LED-1:0] led
);

  localparam int              PRE_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  // Registered state
  mode_t            state;
  logic [N_LED-1:0] pat;
  logic             phase;
  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       rate_cnt;
  logic [3:0]       rate_reg;

  // Next-state values
  mode_t            state_n;
  logic [N_LED-1:0] pat_n;
  logic             phase_n;
  logic [PRE_W-1:0] pre_cnt_n;
  logic [3:0]       rate_cnt_n;
  logic [3:0]       rate_reg_n;
  logic             cmd_ready_n;
  logic             step_pulse_n;
  logic [N_LED-1:0] led_n;

  logic             accept;
  logic             tick;
  logic             step;
  logic [N_LED-1:0] disp;
  logic [N_LED-1:0] disp_gated;

  assign accept = cmd_valid && cmd_ready;
  assign tick   = (state != MODE_OFF) && (pre_cnt == PRE_LAST);
  assign step   = tick && (rate_cnt == rate_reg);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: The reset is synchronous, so it is tested inside the clocked block
  // and is not in the sensitivity list. Every state update uses <= so that all
  // registers sample their pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MODE_OFF;
      pat        <= '0;
      phase      <= 1'b0;
      pre_cnt    <= '0;
      rate_cnt   <= '0;
      rate_reg   <= '0;
      cmd_ready  <= 1'b1;
      step_pulse <= 1'b0;
      led        <= ACTIVE_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};
    end else begin
      state      <= state_n;
      pat        <= pat_n;
      phase      <= phase_n;
      pre_cnt    <= pre_cnt_n;
      rate_cnt   <= rate_cnt_n;
      rate_reg   <= rate_reg_n;
      cmd_ready  <= cmd_ready_n;
      step_pulse <= step_pulse_n;
      led        <= led_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: Every output of this block is given a hold value first, so no path
  // leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_n      = state;
    pat_n        = pat;
    phase_n      = phase;
    pre_cnt_n    = pre_cnt;
    rate_cnt_n   = rate_cnt;
    rate_reg_n   = rate_reg;
    cmd_ready_n  = 1'b1;
    step_pulse_n = 1'b0;

    if (accept) begin
      // An accepted command restarts everything and overrides a
      // coincident step. The ready signal drops for one dead cycle.
      state_n     = mode_t'(cmd_mode);
      rate_reg_n  = cmd_rate;
      pat_n       = cmd_pattern;
      phase_n     = 1'b1;
      pre_cnt_n   = '0;
      rate_cnt_n  = '0;
      cmd_ready_n = 1'b0;
    end else if (state == MODE_OFF) begin
      pre_cnt_n  = '0;
      rate_cnt_n = '0;
    end else begin
      pre_cnt_n = tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) begin
        rate_cnt_n = step ? 4'd0 : rate_cnt + 4'd1;
      end
      if (step) begin
        step_pulse_n = 1'b1;
        case (state)
          MODE_COUNT: pat_n   = pat + N_LED'(1);
          MODE_CHASE: pat_n   = (pat << 1) | (pat >> (N_LED - 1));
          MODE_BLINK: phase_n = ~phase;
          default:    pat_n   = pat;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display. The LED value is computed from the current registers, so what is
  // shown always lags the pattern state by one edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    disp = '0;
    case (state)
      MODE_COUNT, MODE_CHASE: disp = pat;
      MODE_BLINK:             disp = phase ? pat : '0;
      default:                disp = '0;
    endcase
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] duty_reg;
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_reg <= 4'd15;
      pwm_cnt  <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (accept) duty_reg <= cmd_duty;
    end
  end

  // The gating is applied to the logical "lit" value, ahead of any pin
  // polarity inversion.
  assign disp_gated = (pwm_cnt < duty_reg) ? disp : '0;
`else
  assign disp_gated = disp;
`endif

  assign led_n = ACTIVE_LOW ? ~disp_gated : disp_gated;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Scoreboard bench for led_pattern_ctrl (CLK_DIV=4, N_LED=4, ACTIVE_LOW=1).
// A reference process runs at every rising edge. It derives the expected
// post-edge outputs in closed form from the time elapsed since the last
// accepted command: the number of steps is elapsed/period, and the pattern is
// computed from that step count. The result is pushed into a queue. A monitor
// pops the queue on each falling edge and compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int N_LED      = 4;
  localparam bit ACTIVE_LOW = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_mode = 2'd0;
  logic [3:0]       cmd_rate = 4'd0;
  logic [N_LED-1:0] cmd_pattern = '0;
  logic [3:0]       cmd_duty = 4'd15;
  logic             cmd_ready;
  logic             step_pulse;
  logic [N_LED-1:0] led;

  led_pattern_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .N_LED     (N_LED),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_rate   (cmd_rate),
    .cmd_pattern(cmd_pattern),
`ifdef LED_PWM_DIM_EN
    .cmd_duty   (cmd_duty),
`endif
    .step_pulse (step_pulse),
    .led        (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_LED-1:0] led;
    logic             sp;
    logic             rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Logical (pre-polarity) display after n steps of a command.
  function automatic logic [N_LED-1:0] model_disp(input int mode, input logic [N_LED-1:0] start,
                                                  input int n);
    logic [N_LED-1:0] p;
    p = start;
    case (mode)
      1: return N_LED'((int'(start) + n) % (1 << N_LED));
      2: begin
        for (int i = 0; i < n % N_LED; i++) p = {p[N_LED-2:0], p[N_LED-1]};
        return p;
      end
      3: return (n % 2 == 0) ? start : '0;
      default: return '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  initial begin : model
    int               cyc;
    int               acc_c;
    int               rst_c;
    int               m_mode;
    int               m_rate;
    int               period;
    int               n_prev;
    logic [N_LED-1:0] m_pat;
    logic [N_LED-1:0] d;
    logic [3:0]       m_duty;
    bit               m_ready;
    bit               acc;
    exp_t             e;
    cyc = 0; acc_c = 0; rst_c = 0; m_mode = 0; m_rate = 0; m_pat = '0;
    m_duty = 4'd15; m_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        e.led = ACTIVE_LOW ? '1 : '0;
        e.sp  = 1'b0;
        e.rdy = 1'b1;
        m_mode = 0; m_ready = 1'b1; rst_c = cyc; m_duty = 4'd15;
      end else begin
        period = (m_rate + 1) * CLK_DIV;
        n_prev = (cyc - 1 - acc_c) / period;
        d = model_disp(m_mode, m_pat, n_prev);
`ifdef LED_PWM_DIM_EN
        if (((cyc - 1 - rst_c) % 16) >= int'(m_duty)) d = '0;
`endif
        e.led = ACTIVE_LOW ? ~d : d;
        acc   = cmd_valid && m_ready;
        e.sp  = !acc && (m_mode != 0) && (cyc > acc_c) && ((cyc - acc_c) % period == 0);
        e.rdy = !acc;
        m_ready = !acc;
        if (acc) begin
          m_mode = int'(cmd_mode); m_rate = int'(cmd_rate); m_pat = cmd_pattern;
          m_duty = cmd_duty; acc_c = cyc;
        end
      end
      sb.push_back(e);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("led", 32'(led), 32'(e.led));
        check("step_pulse", 32'(step_pulse), 32'(e.sp));
        check("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: each drive() call holds its values across exactly one rising edge
  // ---------------------------------------------------------------------------
  task automatic drive(input bit r, input bit v, input logic [1:0] mode, input logic [3:0] rate,
                       input logic [N_LED-1:0] p, input logic [3:0] duty);
    rst = r; cmd_valid = v; cmd_mode = mode; cmd_rate = rate; cmd_pattern = p; cmd_duty = duty;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'd0, 4'd0, '0, 4'd15);
  endtask

  task automatic send(input logic [1:0] mode, input logic [3:0] rate, input logic [N_LED-1:0] p,
                      input logic [3:0] duty);
    drive(1'b0, 1'b1, mode, rate, p, duty);
  endtask

  initial begin : stim
    // Reset held with a command present: the command must not be taken
    drive(1'b1, 1'b1, 2'd1, 4'd0, 4'h9, 4'd15);
    drive(1'b1, 1'b1, 2'd1, 4'd0, 4'h9, 4'd15);
    idle(3);

    // COUNT from E at the fastest rate, wrapping through F to 0
    send(2'd1, 4'd0, 4'hE, 4'd15);
    idle(14);

    // CHASE seed 1, rate 1, full rotation and back
    send(2'd2, 4'd1, 4'h1, 4'd15);
    idle(40);

    // BLINK mask 5, then OFF
    send(2'd3, 4'd0, 4'h5, 4'd15);
    idle(13);
    send(2'd0, 4'd0, 4'h0, 4'd15);
    idle(10);

    // A new command lands on the same edge as a step, followed by a
    // command in the dead cycle that must be ignored
    send(2'd1, 4'd0, 4'h0, 4'd15);
    idle(3);
    send(2'd1, 4'd0, 4'h3, 4'd15);
    send(2'd2, 4'd0, 4'hF, 4'd15);
    idle(12);

    // Reset in the middle of a chase
    send(2'd2, 4'd0, 4'h1, 4'd15);
    idle(9);
    drive(1'b1, 1'b0, 2'd0, 4'd0, '0, 4'd15);
    idle(6);

    // Dimmed COUNT at a slow rate with a multi-bit chase seed next
    send(2'd1, 4'd15, 4'hF, 4'd4);
    idle(40);
    send(2'd2, 4'd0, 4'h6, 4'd9);
    idle(20);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 2)), N_LED'($urandom), 4'($urandom));
    end
    idle(3);

    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
